// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0-3 byte slave with synchronized bus inputs and a one-byte transmit holding register.
// Bus inputs are oversampled by clk; all bus activity is recognised SYNC_STAGES+1 clocks after the pins.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       underrun,
  output logic       busy
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q, vld_q;
  logic                   sclk_d, armed;
  logic [0:0]             state;
  logic [2:0]             cnt;
  logic [7:0]             tx, rx, hold;
  logic                   hold_v, skip;
  logic                   sck, ssn, sdi, tgl, lead, trail;
  logic                   act, smp, shf, start_idle, wrap, start, load;

  assign sck        = sclk_q[SYNC_STAGES-1];
  assign ssn        = ss_q[SYNC_STAGES-1];
  assign sdi        = mosi_q[SYNC_STAGES-1];
  assign tgl        = sck ^ sclk_d;
  assign lead       = tgl & (sclk_d == cpol);
  assign trail      = tgl & (sck == cpol);
  assign act        = (state == ACTIVE) & ~ssn;
  assign smp        = act & (cpha ? trail : lead);
  assign shf        = act & (cpha ? lead : trail);
  assign start_idle = (state == IDLE) & armed & ~ssn;
  assign wrap       = smp & (cnt == 3'd7);
  assign start      = start_idle | wrap;
  assign load       = din_valid & din_ready;
  assign busy       = state == ACTIVE;
  assign miso_oe    = busy;
  assign miso       = busy & tx[7];
  assign din_ready  = ~hold_v;

  // vld_q tracks when the synchronizer holds real pin values again after reset,
  // so a select that was already low across reset is not mistaken for a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      vld_q  <= '0;
      sclk_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d <= sck;
      armed  <= armed | (vld_q[SYNC_STAGES-1] & ssn);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      rx         <= 8'h00;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
    end else begin
      state      <= (~ssn & ((state == ACTIVE) | armed)) ? ACTIVE : IDLE;
      cnt        <= act ? cnt + {2'b00, smp} : 3'd0;
      rx         <= act ? (smp ? {rx[6:0], sdi} : rx) : 8'h00;
      dout       <= wrap ? {rx[6:0], sdi} : dout;
      dout_valid <= wrap;
    end
  end

  // after any byte start the next edge of the byte is a shift edge except
  // for a mode with cpha=0 starting from idle; that edge must not shift bit 7 away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 8'h00;
      skip     <= 1'b0;
      hold     <= 8'h00;
      hold_v   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (start) begin
        tx   <= hold_v ? hold : 8'h00;
        skip <= wrap | cpha;
      end else if (shf) begin
        tx   <= skip ? tx : {tx[6:0], 1'b0};
        skip <= 1'b0;
      end
      hold     <= load ? din : hold;
      hold_v   <= load | (hold_v & ~start);
      underrun <= start & ~hold_v;
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bit-level SPI master with a byte/queue model of the slave, directed mode/burst/abort/reset cases and random bursts.
module tb_spi_slave;
  localparam int S = 2;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst, cpol, cpha, sclk, ss_n, mosi, din_valid;
  logic [7:0] din, dout;
  logic       miso, miso_oe, din_ready, dout_valid, underrun, busy;

  int         errors = 0, checks = 0;
  logic [7:0] exp_rx [1024];
  int         exp_n = 0, got_n = 0, exp_un = 0, got_un = 0;
  logic [7:0] cur_dout = 8'h00;
  logic [7:0] m_hold, m_tx;
  bit         m_hold_v, m_armed;
  logic [7:0] mo_q[$], feed_q[$], miso_q[$];
  int         n0, u0;

  spi_slave #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // byte start: the holding register moves to the transmitter, or zero with an underrun
  task automatic byte_start();
    if (!m_armed) return;
    if (m_hold_v) m_tx = m_hold;
    else begin
      m_tx = 8'h00;
      exp_un++;
    end
    m_hold_v = 1'b0;
  endtask

  task automatic offer(input logic [7:0] v);
    chk("din_ready", 32'(din_ready), 32'(!m_hold_v));
    din = v;
    din_valid = 1'b1;
    step(1);
    din_valid = 1'b0;
    if (!m_hold_v) begin
      m_hold = v;
      m_hold_v = 1'b1;
    end
  endtask

  task automatic half(input bit fd);
    if (fd && feed_q.size() > 0) begin
      step(5);
      offer(feed_q.pop_front());
      step(H - 6);
    end else step(H);
  endtask

  task automatic set_mode(input int m);
    cpol = m[1];
    cpha = m[0];
    sclk = cpol;
    step(H);
  endtask

  task automatic select();
    sclk = cpol;
    ss_n = 1'b0;
    byte_start();
  endtask

  task automatic burst(input int nbits, input bit desel);
    logic [7:0] mb, rb, cb;
    int bp;
    bit fp;
    mb = 8'h00; rb = 8'h00; cb = 8'h00; fp = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bp = 7 - (i % 8);
      if (bp == 7) mb = (mo_q.size() > 0) ? mo_q.pop_front() : 8'($urandom);
      if (!cpha) begin
        mosi = mb[bp];
        half(1'b0);
      end else begin
        half(fp);
        fp = 1'b0;
        sclk = ~cpol;
        mosi = mb[bp];
        half(1'b0);
      end
      chk("miso_bit", 32'(miso), 32'(m_tx[bp]));
      cb = {cb[6:0], miso};
      rb = {rb[6:0], mb[bp]};
      sclk = cpha ? cpol : ~cpol;
      if (bp == 7) fp = 1'b1;
      if (bp == 0) begin
        exp_rx[exp_n] = rb;
        exp_n++;
        miso_q.push_back(cb);
        byte_start();
      end
      if (!cpha) begin
        half(fp);
        fp = 1'b0;
        sclk = cpol;
      end
    end
    half(fp);
    if (desel) begin
      ss_n = 1'b1;
      step(H);
      chk("busy_after_desel", 32'(busy), 32'(0));
      chk("oe_after_desel", 32'(miso_oe), 32'(0));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cur_dout <= 8'h00;
      chk("rst_outputs", 32'({miso, miso_oe, din_ready, dout, dout_valid, underrun, busy}),
          32'({1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}));
    end else begin
      chk("miso_oe_eq_busy", 32'(miso_oe), 32'(busy));
      if (!miso_oe) chk("miso_idle", 32'(miso), 32'(0));
      if (dout_valid) begin
        chk("dout_pending", 32'(got_n < exp_n), 32'(1));
        chk("dout", 32'(dout), 32'(exp_rx[got_n]));
        cur_dout <= exp_rx[got_n];
        got_n <= got_n + 1;
      end else chk("dout_hold", 32'(dout), 32'(cur_dout));
      if (underrun) begin
        chk("underrun_pending", 32'(got_un < exp_un), 32'(1));
        got_un <= got_un + 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    din = 8'h00; din_valid = 1'b0;
    m_hold = 8'h00; m_tx = 8'h00; m_hold_v = 1'b0; m_armed = 1'b0;
    step(3);
    rst = 1'b0;
    step(H);
    m_armed = 1'b1;
    chk("reset_din_ready", 32'(din_ready), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_dout", 32'(dout), 32'(8'h00));

    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      n0 = got_n;
      miso_q.delete();
      offer(8'hA5);
      mo_q.push_back(8'h3C);
      select();
      burst(8, 1'b1);
      chk("mode_miso_byte", 32'(miso_q[0]), 32'(8'hA5));
      chk("mode_dout", 32'(dout), 32'(8'h3C));
      chk("mode_pulses", 32'(got_n - n0), 32'(1));
    end

    set_mode(0);
    n0 = got_n; u0 = got_un;
    miso_q.delete();
    offer(8'h01);
    feed_q = '{8'h02, 8'h03, 8'hEE};
    mo_q = '{8'h81, 8'h42, 8'h24};
    select();
    burst(24, 1'b1);
    chk("burst_miso0", 32'(miso_q[0]), 32'(8'h01));
    chk("burst_miso1", 32'(miso_q[1]), 32'(8'h02));
    chk("burst_miso2", 32'(miso_q[2]), 32'(8'h03));
    chk("burst_pulses", 32'(got_n - n0), 32'(3));
    chk("burst_no_underrun", 32'(got_un - u0), 32'(0));
    chk("burst_dout", 32'(dout), 32'(8'h24));

    set_mode(3);
    u0 = got_un;
    miso_q.delete();
    mo_q.push_back(8'h5A);
    select();
    burst(8, 1'b1);
    chk("empty_miso_byte", 32'(miso_q[0]), 32'(8'h00));
    chk("empty_dout", 32'(dout), 32'(8'h5A));
    chk("empty_underruns", 32'(got_un - u0), 32'(2));

    set_mode(2);
    n0 = got_n;
    miso_q.delete();
    offer(8'h77);
    feed_q.push_back(8'h88);
    mo_q.push_back(8'h96);
    select();
    burst(5, 1'b1);
    chk("abort_no_pulse", 32'(got_n - n0), 32'(0));
    chk("abort_dout_kept", 32'(dout), 32'(8'h5A));
    chk("abort_oe", 32'(miso_oe), 32'(0));
    mo_q.push_back(8'hC3);
    select();
    burst(8, 1'b1);
    chk("after_abort_dout", 32'(dout), 32'(8'hC3));
    chk("after_abort_miso", 32'(miso_q[0]), 32'(8'h88));

    set_mode(1);
    offer(8'h11);
    mo_q.push_back(8'h22);
    select();
    burst(4, 1'b0);
    rst = 1'b1;
    m_hold_v = 1'b0;
    m_armed = 1'b0;
    step(2);
    chk("midrst_dout", 32'(dout), 32'(8'h00));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_din_ready", 32'(din_ready), 32'(1));
    rst = 1'b0;
    n0 = got_n; u0 = got_un;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      step(H);
      sclk = ~sclk;
    end
    step(H);
    chk("midrst_no_pulse", 32'(got_n - n0), 32'(0));
    chk("midrst_no_underrun", 32'(got_un - u0), 32'(0));
    chk("midrst_still_idle", 32'(busy), 32'(0));
    ss_n = 1'b1;
    sclk = cpol;
    step(H);
    m_armed = 1'b1;
    miso_q.delete();
    offer(8'h4B);
    mo_q.push_back(8'hD2);
    select();
    burst(8, 1'b1);
    chk("post_rst_dout", 32'(dout), 32'(8'hD2));
    chk("post_rst_miso", 32'(miso_q[0]), 32'(8'h4B));

    for (int r = 0; r < 16; r++) begin
      set_mode(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) offer(8'($urandom));
      for (int k = $urandom_range(0, 4); k > 0; k--) feed_q.push_back(8'($urandom));
      select();
      burst(int'($urandom_range(1, 32)), 1'b1);
      feed_q.delete();
    end

    step(H);
    chk("total_dout_pulses", 32'(got_n), 32'(exp_n));
    chk("total_underruns", 32'(got_un), 32'(exp_un));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
